// File: rtl/mtm_alu_pkg.sv
// mtm_alu_pkg -- shared protocol constants for the MTM ALU serial front end.
//   operation_t  : supported ALU operations (AND, OR, ADD, SUB)
//   PKT_*        : packet type bit values
//   DATA_PKTS    : data packets per command frame
//   CRC4_POLY    : low bits of x^4+x+1
//   ERR_*_BIT    : bit positions inside err_flags_o ({DATA, CRC, OP})
//   state_t      : deserializer FSM states
//   op_valid()   : true for the supported operation codes
package mtm_alu_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } operation_t;

  localparam logic PKT_DATA = 1'b0;
  localparam logic PKT_CMD  = 1'b1;

  localparam logic [3:0] DATA_PKTS = 4'd8;

  localparam logic [3:0] CRC4_POLY = 4'b0011;

  localparam int ERR_DATA_BIT = 2;
  localparam int ERR_CRC_BIT  = 1;
  localparam int ERR_OP_BIT   = 0;

  localparam logic [2:0] ERR_DATA = 3'b001 << ERR_DATA_BIT;
  localparam logic [2:0] ERR_CRC  = 3'b001 << ERR_CRC_BIT;
  localparam logic [2:0] ERR_OP   = 3'b001 << ERR_OP_BIT;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_CHECK
  } state_t;

  function automatic logic op_valid(input logic [2:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mtm_alu_deserializer_if.sv
// mtm_alu_deserializer_if -- serial input and decoded outputs of the deserializer.
//   sin         : serial stream, idle high
//   a_o, b_o    : 32-bit operands, valid with valid_o
//   op_o        : 3-bit operation code, valid with valid_o
//   valid_o     : one-cycle pulse, good command frame decoded
//   err_o       : one-cycle pulse, frame rejected
//   err_flags_o : {ERR_DATA, ERR_CRC, ERR_OP} one-hot, valid with err_o
// Modports: slave = deserializer, master = stream source / consumer.
interface mtm_alu_deserializer_if;
  logic        sin;
  logic [31:0] a_o;
  logic [31:0] b_o;
  logic [2:0]  op_o;
  logic        valid_o;
  logic        err_o;
  logic [2:0]  err_flags_o;

  modport slave (
    input  sin,
    output a_o, b_o, op_o, valid_o, err_o, err_flags_o
  );

  modport master (
    output sin,
    input  a_o, b_o, op_o, valid_o, err_o, err_flags_o
  );
endinterface

// File: rtl/mtm_alu_crc4_serial.sv
// mtm_alu_crc4_serial -- bit-serial CRC-4 (x^4+x+1), init 0, MSB first.
//   clk, rst : clock, async active-high reset
//   clear    : synchronous return to 0 (wins over en)
//   en, din  : shift one message bit in
//   crc      : current remainder
module mtm_alu_crc4_serial
  import mtm_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       en,
  input  logic       din,
  output logic [3:0] crc
);

  logic fb;
  assign fb = crc[3] ^ din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[2:0], 1'b0} ^ ({4{fb}} & CRC4_POLY);
    end
  end

endmodule

// File: rtl/mtm_alu_deserializer.sv
// mtm_alu_deserializer -- decodes the MTM ALU serial stream into operands/op.
// Packets are 11 bits: start 0, type, 8-bit payload, stop 1. Eight data
// packets carry A then B (MSB byte first); a command packet carries
// {0, op, crc}. Every frame ends in one CHECK cycle that pulses either
// valid_o or err_o.
//   clk, rst : clock, async active-high reset
//   bus      : mtm_alu_deserializer_if.slave (sin in, decoded outputs out)
module mtm_alu_deserializer
  import mtm_alu_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  mtm_alu_deserializer_if.slave         bus
);

  state_t      state;
  logic [3:0]  bitcnt;    // 0 = type, 1..8 = payload, 9 = stop
  logic [3:0]  dcnt;      // data packets since last frame end, saturates at 9
  logic        stop_bad;  // CHECK entered because a stop bit sampled 0

  logic [63:0] sr;
  logic [7:0]  pay;
  logic        pkt_type;

  logic        crc_clear;
  logic        crc_en;
  logic        crc_din;
  logic [3:0]  crc;

  mtm_alu_crc4_serial u_crc (
    .clk   (clk),
    .rst   (rst),
    .clear (crc_clear),
    .en    (crc_en),
    .din   (crc_din),
    .crc   (crc)
  );

  // Data payload bits feed the CRC as received; a command packet feeds a
  // constant 1 in place of its payload bit 7, then the three op bits.
  always_comb begin
    crc_clear = (state == S_CHECK);
    crc_en    = 1'b0;
    crc_din   = bus.sin;
    if (state == S_RECV && bitcnt >= 4'd1 && bitcnt <= 4'd8) begin
      if (pkt_type == PKT_DATA) begin
        crc_en = 1'b1;
      end else if (bitcnt == 4'd1) begin
        crc_en  = 1'b1;
        crc_din = 1'b1;
      end else if (bitcnt <= 4'd4) begin
        crc_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      bitcnt          <= '0;
      dcnt            <= '0;
      stop_bad        <= 1'b0;
      bus.a_o         <= '0;
      bus.b_o         <= '0;
      bus.op_o        <= '0;
      bus.valid_o     <= 1'b0;
      bus.err_o       <= 1'b0;
      bus.err_flags_o <= '0;
    end else begin
      bus.valid_o     <= 1'b0;
      bus.err_o       <= 1'b0;
      bus.err_flags_o <= '0;
      case (state)
        S_IDLE: begin
          if (!bus.sin) begin
            state  <= S_RECV;
            bitcnt <= '0;
          end
        end
        S_RECV: begin
          if (bitcnt == 4'd9) begin
            stop_bad <= !bus.sin;
            // A broken stop bit is reported through CHECK so its error pulse
            // lands one clock after the stop sample, like a command result.
            if (!bus.sin || pkt_type == PKT_CMD) begin
              state <= S_CHECK;
            end else begin
              state <= S_IDLE;
              if (dcnt <= DATA_PKTS) dcnt <= dcnt + 4'd1;
            end
          end else begin
            bitcnt <= bitcnt + 4'd1;
          end
        end
        S_CHECK: begin
          dcnt     <= '0;
          stop_bad <= 1'b0;
          if (stop_bad || dcnt != DATA_PKTS) begin
            bus.err_o       <= 1'b1;
            bus.err_flags_o <= ERR_DATA;
          end else if (crc != pay[3:0]) begin
            bus.err_o       <= 1'b1;
            bus.err_flags_o <= ERR_CRC;
          end else if (!op_valid(pay[6:4])) begin
            bus.err_o       <= 1'b1;
            bus.err_flags_o <= ERR_OP;
          end else begin
            bus.valid_o <= 1'b1;
            bus.a_o     <= sr[63:32];
            bus.b_o     <= sr[31:0];
            bus.op_o    <= pay[6:4];
          end
          // The next frame may start right away with no idle bits.
          state  <= bus.sin ? S_IDLE : S_RECV;
          bitcnt <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_RECV) begin
      if (bitcnt == 4'd0) begin
        pkt_type <= bus.sin;
      end else if (bitcnt <= 4'd8) begin
        pay <= {pay[6:0], bus.sin};
      end else if (pkt_type == PKT_DATA && bus.sin) begin
        sr <= {sr[55:0], pay};
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_deserializer.sv
// tb_mtm_alu_deserializer -- directed and randomized frames against a
// byte-level reference model (CRC by polynomial long division).
module tb_mtm_alu_deserializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mtm_alu_deserializer_if bus();

  mtm_alu_deserializer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit both_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [2:0]  flags;
    int          cyc;
  } ev_t;

  ev_t obs_q[$];
  ev_t exp_q[$];

  // reference model state
  logic [7:0]  mbytes[$];
  logic [31:0] exp_a;
  logic [31:0] exp_b;
  logic [2:0]  exp_op;

  always @(negedge clk) begin
    ev_t e;
    if (bus.valid_o || bus.err_o) begin
      e.is_err = bus.err_o;
      e.a      = bus.a_o;
      e.b      = bus.b_o;
      e.op     = bus.op_o;
      e.flags  = bus.err_o ? bus.err_flags_o : 3'b000;
      e.cyc    = cyc;
      obs_q.push_back(e);
    end
    if (bus.valid_o && bus.err_o) both_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] crc_ref(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    logic [71:0] m;
    m = {a, b, 1'b1, op, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (m[i]) m[i -: 5] = m[i -: 5] ^ 5'b10011;
    return m[3:0];
  endfunction

  task automatic send_bit(input logic b);
    bus.sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic send_packet(input logic typ, input logic [7:0] pl, input logic stop,
                             output int stop_cyc);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(pl[i]);
    send_bit(stop);
    stop_cyc = cyc;
  endtask

  task automatic push_err(input logic [2:0] flags, input int c);
    ev_t e;
    e.is_err = 1'b1; e.a = exp_a; e.b = exp_b; e.op = exp_op;
    e.flags = flags; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic data_pkt(input logic [7:0] by, input logic stop_ok);
    int sc;
    send_packet(1'b0, by, stop_ok, sc);
    if (stop_ok) begin
      mbytes.push_back(by);
    end else begin
      push_err(3'b100, sc + 1);
      mbytes.delete();
    end
  endtask

  task automatic cmd_pkt(input logic [2:0] op, input logic [3:0] flip);
    logic [31:0] ea, eb;
    logic [3:0]  c, rx;
    int          sc;
    bit          opok;
    ev_t         e;
    ea = '0; eb = '0;
    if (mbytes.size() == 8)
      for (int k = 0; k < 4; k++) begin
        ea = {ea[23:0], mbytes[k]};
        eb = {eb[23:0], mbytes[k + 4]};
      end
    c  = crc_ref(ea, eb, op);
    rx = c ^ flip;
    send_packet(1'b1, {1'b0, op, rx}, 1'b1, sc);
    opok = (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b101);
    if (mbytes.size() != 8)  push_err(3'b100, sc + 1);
    else if (rx != c)        push_err(3'b010, sc + 1);
    else if (!opok)          push_err(3'b001, sc + 1);
    else begin
      exp_a = ea; exp_b = eb; exp_op = op;
      e.is_err = 1'b0; e.a = ea; e.b = eb; e.op = op; e.flags = 3'b000; e.cyc = sc + 1;
      exp_q.push_back(e);
    end
    mbytes.delete();
  endtask

  task automatic frame(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [3:0] flip, input int ndata, input int gap);
    logic [63:0] ab;
    logic [7:0]  by;
    ab = {a, b};
    for (int k = 0; k < ndata; k++) begin
      by = (k < 8) ? ab[63 - 8*k -: 8] : 8'($urandom);
      data_pkt(by, 1'b1);
      idle(gap);
    end
    cmd_pkt(op, flip);
  endtask

  task automatic drain(input string tag);
    int n;
    idle(3);
    chk({tag, ".count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, ".kind"},  64'(obs_q[i].is_err), 64'(exp_q[i].is_err));
      chk({tag, ".cyc"},   64'(obs_q[i].cyc),    64'(exp_q[i].cyc));
      chk({tag, ".flags"}, 64'(obs_q[i].flags),  64'(exp_q[i].flags));
      chk({tag, ".a"},     64'(obs_q[i].a),      64'(exp_q[i].a));
      chk({tag, ".b"},     64'(obs_q[i].b),      64'(exp_q[i].b));
      chk({tag, ".op"},    64'(obs_q[i].op),     64'(exp_q[i].op));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".a"},     64'(bus.a_o),         64'h0);
    chk({tag, ".b"},     64'(bus.b_o),         64'h0);
    chk({tag, ".op"},    64'(bus.op_o),        64'h0);
    chk({tag, ".valid"}, 64'(bus.valid_o),     64'h0);
    chk({tag, ".err"},   64'(bus.err_o),       64'h0);
    chk({tag, ".flags"}, 64'(bus.err_flags_o), 64'h0);
  endtask

  initial begin
    int sc;
    logic [31:0] ra, rb;
    logic [3:0]  rflip;
    int          rnd;
    exp_a = '0; exp_b = '0; exp_op = '0;
    rst = 1'b1;
    bus.sin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 1'b0;
    idle(2);

    // A=10, B=20, ADD, correct CRC
    frame(32'd10, 32'd20, 3'b100, 4'h0, 8, 1);
    drain("add_ok");
    chk("add_ok.a_const",  64'(bus.a_o),  64'h0000000A);
    chk("add_ok.b_const",  64'(bus.b_o),  64'h00000014);
    chk("add_ok.op_const", 64'(bus.op_o), 64'h4);

    // same frame, CRC LSB flipped
    frame(32'd10, 32'd20, 3'b100, 4'h1, 8, 0);
    drain("crc_err");

    // seven data packets, then a good frame
    frame(32'h12345678, 32'h9ABCDEF0, 3'b000, 4'h0, 7, 0);
    frame(32'd1, 32'd2, 3'b000, 4'h0, 8, 0);
    drain("short_then_ok");

    // unsupported op with matching CRC
    frame(32'hCAFEF00D, 32'h0BADBEEF, 3'b010, 4'h0, 8, 2);
    drain("bad_op");

    // stop bit 0 in packet 3, then a good frame
    data_pkt(8'hA1, 1'b1);
    data_pkt(8'hB2, 1'b1);
    data_pkt(8'hC3, 1'b0);
    idle(1);
    frame(32'h00FF00FF, 32'h7FFFFFFF, 3'b001, 4'h0, 8, 0);
    drain("stop_err");

    // reset in the middle of packet 4
    for (int k = 0; k < 3; k++) data_pkt(8'h5A, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    #2;
    rst = 1'b1;
    bus.sin = 1'b1;
    #1;
    chk_reset_state("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    mbytes.delete();
    exp_a = '0; exp_b = '0; exp_op = '0;
    idle(2);
    frame(32'hFFFFFFFF, 32'h80000000, 3'b101, 4'h0, 8, 0);
    drain("after_rst");
    chk("after_rst.a_const", 64'(bus.a_o),  64'hFFFFFFFF);
    chk("after_rst.b_const", 64'(bus.b_o),  64'h80000000);
    chk("after_rst.op_const", 64'(bus.op_o), 64'h5);

    // back-to-back frames with no idle bits anywhere
    frame(32'h01020304, 32'h05060708, 3'b001, 4'h0, 8, 0);
    frame(32'h11111111, 32'h22222222, 3'b101, 4'h0, 8, 0);
    frame(32'h33333333, 32'h44444444, 3'b100, 4'h0, 8, 0);
    drain("b2b");

    // randomized frames
    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      rb = $urandom;
      rflip = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      rnd = $urandom_range(0, 9);
      frame(ra, rb, 3'($urandom_range(0, 7)), rflip,
            (rnd == 0) ? 7 : (rnd == 1) ? 9 : 8, $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    drain("random");

    sc = 0;
    chk("never_both", 64'(both_seen), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
